// File: rtl/uart4_rx.sv
// uart4_rx: 8N1 receiver that assembles four bytes, least significant byte first, into a 32-bit word
module uart4_rx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rx,
    output logic [31:0] data,
    output logic        valid,
    output logic        framing_error,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [IW-1:0] IDLE_LAST = IW'(LIMIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    state_t state, state_n;
    logic rx_m, rx_s, tick, pend;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idle_cnt;
    logic [2:0] bit_idx;
    logic [1:0] byte_idx;
    logic [7:0] shreg;
    logic [31:0] word;

    assign tick = cnt == CW'(1);
    assign busy = state inside {START, DATA, STOP};

    always_ff @(posedge clk) state <= !nrst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = rx_s ? IDLE : START;
            START:     state_n = !tick ? START : rx_s ? IDLE : DATA;
            DATA:      state_n = (tick && bit_idx == 3'd7) ? STOP : DATA;
            STOP:      state_n = !tick ? STOP : rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            cnt <= '0;
            idle_cnt <= '0;
            bit_idx <= '0;
            byte_idx <= '0;
            shreg <= '0;
            word <= '0;
            pend <= 1'b0;
            data <= '0;
            valid <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            // IDLE keeps the half-bit count preloaded so START samples mid start bit
            cnt <= (state == IDLE) ? HALF : tick ? FULL : cnt - CW'(1);
            bit_idx <= (state == DATA) ? bit_idx + 3'(tick) : '0;
            pend <= 1'b0;
            valid <= pend;
            framing_error <= 1'b0;
            if (pend) data <= word;
            if (state == DATA && tick) shreg <= {rx_s, shreg[7:1]};
            if (state == STOP && tick) begin
                if (rx_s) begin
                    word[{byte_idx, 3'b000} +: 8] <= shreg;
                    byte_idx <= byte_idx + 2'd1;
                    pend <= byte_idx == 2'd3;
                end else begin
                    framing_error <= 1'b1;
                    byte_idx <= '0;
                    word <= '0;
                end
            end
            // inter-byte timeout discards a stale partial word
            if (state == IDLE && byte_idx != '0 && rx_s) begin
                idle_cnt <= idle_cnt + IW'(1);
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt <= '0;
                    byte_idx <= '0;
                    word <= '0;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end
endmodule

// File: doc/uart4_rx.md
Name: uart4_rx

Overview:
- Receive side of the 4-byte UART link.
- Deserialises 8N1 frames from a single rx line and assembles four consecutive bytes into one 32-bit word, least significant byte first.
- Presents the word with a one-cycle valid strobe.
- Used on the host/bench side to reassemble the frequency-code words sent by the probe's 4-byte transmitter, and for loopback checking of that transmitter.

Parameters:
- CLKS_PER_BIT, 234: clk cycles per bit period (27 MHz / 115200). Must be >= 4.
- TIMEOUT_BITS, 20: idle bit periods between bytes after which a partially assembled word is discarded.

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  32  last complete word; byte0 in [7:0] … byte3 in [31:24]
- valid  output  1  one-cycle pulse when data is updated
- framing_error  output  1  one-cycle pulse on a bad stop bit
- busy  output  1  high from start-bit detection until stop-bit sample completes

Behaviour:
- Reset (nrst low at a clk edge):
  - data=0, valid=0, framing_error=0, busy=0.
  - Byte index=0, partial word cleared, FSM=IDLE, synchroniser flops set to 1.
  - Reset mid-frame aborts the frame silently, with no pulses.
- Input synchronisation: rx passes through 2 flops; all logic uses the synchronised rx_s. This adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 -> START; bit counter = CLKS_PER_BIT/2 (integer divide); busy=1.
- START (sample at mid start bit):
  - When the counter expires: if rx_s==1 it was a false start -> IDLE, busy=0, nothing else changes.
  - Otherwise -> DATA with bit index 0 and counter = CLKS_PER_BIT.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles.
  - Shift into the byte register LSB first.
  - After 8 samples -> STOP with counter = CLKS_PER_BIT.
- STOP (sampled one bit period after the last data bit):
  - rx_s==1 (good frame): store the byte at the byte index.
    - If the index is 3: on the next clk, data <= the assembled word, valid=1 for exactly one cycle, and the index returns to 0.
    - Otherwise the index increments.
    - Next state IDLE; busy=0.
  - rx_s==0 (bad frame): framing_error=1 for one cycle; discard the byte and the partial word; index=0; -> WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then -> IDLE.
  - A break condition (held low) therefore never retriggers a start.
- Inter-byte timeout:
  - An idle counter runs in IDLE while the byte index != 0.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles: index=0, partial word discarded, no pulse.
  - The counter clears on every start detection.
  - Counter width must hold the product without overflow.
- data holds its value between valid pulses and is never modified by partial or failed words.
- valid and framing_error never assert in the same cycle.
- A start bit immediately following a stop bit, with zero idle cycles, must be accepted. Back-to-back frames at full rate must not be lost.
- Latency: valid rises 1 cycle after the clk edge that samples the 4th stop bit.

Test Plan:
- Send bytes 0x78,0x56,0x34,0x12 back-to-back at CLKS_PER_BIT=234.
  -> One valid pulse, 1 cycle wide; data=0x12345678; framing_error never high.
- Drive rx low for 100 cycles (< 117), then high.
  -> Returns to IDLE; busy pulses then drops; no valid, no framing_error; data unchanged.
- Send 0x11, then 0x22 with stop bit forced 0, then line high, then 0xAA,0xBB,0xCC,0xDD.
  -> framing_error pulses once; a single valid follows with data=0xDDCCBBAA.
- Send 0x01,0x02, idle 25 bit periods, then 0x03,0x04,0x05,0x06.
  -> Exactly one valid, with data=0x06050403.
- Hold rx low for 30 bit periods, then release and send a full word 0xCAFEBABE.
  -> One framing_error pulse, no restart while low, then valid with data=0xCAFEBABE.
- Assert nrst low for 1 cycle in the middle of the third byte of a word, then send a full word 0x00000001.
  -> All outputs 0 after reset; next valid carries data=0x00000001.
